inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage that sits directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM's addr/ready request.
- Captures the returned instruction word and its PC into a small queue, and presents them to decode with a valid/ready handshake.
- Folds unconditional Jump instructions (opcode 4'b1010) inside fetch, and accepts a redirect/flush from execute for future branch support.

Parameters:
- DWIDTH, 16, instruction word width.
- AWIDTH, 16, PC / ROM address width.
- QDEPTH, 2, instruction queue entries; power of 2, >= 2.
- PC_RESET, 0, PC value after reset.
- JMP_OP, 4'b1010, opcode in inst[15:12] that fetch folds.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  AWIDTH  fetch address; equals current pc.
- rom_ready  out  1  fetch request to ROM.
- rom_data  in  DWIDTH  instruction word from ROM; combinational, same cycle as the request.
- rom_valid  in  1  ROM data valid; combinational, same cycle as the request.
- redirect_valid  in  1  execute-stage redirect; flushes the queue.
- redirect_pc  in  AWIDTH  new PC on redirect.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts the head.
- inst  out  DWIDTH  queue head instruction.
- inst_pc  out  AWIDTH  PC of the queue head.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=PC_RESET, queue count=0, rd/wr pointers=0.
  - inst_valid=0, inst=0, inst_pc=0.
  - rom_ready forced 0 combinationally while rst=1.
- Internal strobes:
  - pop = inst_valid & inst_ready.
  - full = (count==QDEPTH).
- rom_ready = !rst & !redirect_valid & (!full | pop). This is combinational; a fetch is allowed when a slot frees the same cycle.
- rom_addr = pc at all times.
- Capture happens when rom_ready & rom_valid. Then at the edge:
  - If rom_data[15:12]==JMP_OP: pc <= {zero-ext rom_data[7:0]}. The word is NOT enqueued.
  - Else: push {pc, rom_data}, then pc <= pc+1, wrapping modulo 2^AWIDTH.
- rom_ready=1 with rom_valid=0: no push, pc holds, retried next cycle.
- Latency: a word fetched in cycle N is visible at the head (inst_valid=1) in cycle N+1 if the queue was empty. Sustained throughput is 1 inst/cycle with inst_ready=1.
- Queue behaviour:
  - Circular buffer; count updated by push/pop.
  - Push and pop in the same cycle: count unchanged.
  - Never push when full without a pop; never pop when empty.
- Redirect (redirect_valid=1 at an edge) has priority over everything:
  - pc <= redirect_pc; count <= 0; pointers reset.
  - No fetch that cycle, since rom_ready=0.
  - A pop handshake completing in the same cycle counts as a completed transfer to decode; all other entries are discarded.
- Jump to self (e.g. a Jump at address k targeting k): fetch loops with no pushes. This is legal, and inst_valid stays 0 once drained.
- inst/inst_pc/inst_valid come from registered queue storage; there is no combinational path from rom_data to inst.

Test Plan:
1. Hold rst=1 for 3 cycles -> rom_ready=0, inst_valid=0, inst=0 throughout. First cycle after release: rom_addr=0x0000, rom_ready=1.
2. Stream with inst_ready=1 (ROM: 0x0008,0x0402,0x2401,0x5100,0x9100,0x2001,0xA008,0x5100,0x08FF,0x0E00,0xA009) -> inst/inst_pc sequence is 0x0008@0, 0x0402@1, 0x2401@2, 0x5100@3, 0x9100@4, 0x2001@5, 0x08FF@8, one per cycle. Specifically: 0xA008 never appears, 0x5100@7 never appears, and 0x08FF@8 follows 0x2001@5 with at most one bubble.
3. Loop folding -> after 0x0E00@9, the Jump at 10 returns to 9. 0x0E00@9 repeats every 2 cycles indefinitely, and inst_pc is never 10.
4. Backpressure: inst_ready=0 for 6 cycles after reset -> count saturates at 2, rom_ready=0, pc holds at 2. Raise inst_ready -> 0x0008, 0x0402, 0x2401 in order, no loss or duplication.
5. Redirect with 2 entries queued and inst_ready=0, redirect_pc=3 -> next cycle inst_valid=0, rom_addr=3. The following cycle inst=0x5100, inst_pc=3.
6. Redirect in the same cycle as a pop and a rom_valid fetch -> the popped entry is delivered once, the fetched word is not enqueued, and pc=redirect_pc. Separately: rst asserted while the queue is full -> inst_valid=0 and pc=0 next cycle.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, requests words from the instruction ROM, folds
// unconditional jumps and queues {pc, inst} pairs for decode behind valid/ready.
module inst_fetch #(
  parameter int              DWIDTH   = 16,
  parameter int              AWIDTH   = 16,
  parameter int              QDEPTH   = 2,
  parameter logic [AWIDTH-1:0] PC_RESET = '0,
  parameter logic [3:0]      JMP_OP   = 4'b1010
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] rom_addr,
  output logic              rom_ready,
  input  logic [DWIDTH-1:0] rom_data,
  input  logic              rom_valid,
  input  logic              redirect_valid,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DWIDTH-1:0] inst,
  output logic [AWIDTH-1:0] inst_pc
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] q_inst [QDEPTH];
  logic [AWIDTH-1:0] q_pc   [QDEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  logic pop;
  logic full;
  logic capture;
  logic is_jump;
  logic push;

  // Head comes straight from registered storage; no path from rom_data to inst.
  assign inst_valid = (count != '0);
  assign inst       = q_inst[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  assign pop       = inst_valid & inst_ready;
  assign full      = (count == CW'(QDEPTH));
  assign rom_ready = !rst && !redirect_valid && (!full || pop);
  assign rom_addr  = pc;
  assign capture   = rom_ready & rom_valid;
  assign is_jump   = (rom_data[15:12] == JMP_OP);
  assign push      = capture & !is_jump;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= PC_RESET;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      // Any pop this cycle already completed to decode; the rest is discarded.
      pc     <= redirect_pc;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (capture) begin
        pc <= is_jump ? AWIDTH'(rom_data[7:0]) : pc + AWIDTH'(1);
      end
      if (push) begin
        q_inst[wr_ptr] <= rom_data;
        q_pc[wr_ptr]   <= pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid) begin
      assert (!(push && full && !pop));
      assert (!(pop && !inst_valid));
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized traffic, scored against
// a program-walk model of which {pc, word} pairs decode must receive, in order.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rom_addr;
  logic        rom_ready;
  logic [15:0] rom_data;
  logic        rom_valid = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [15:0] inst;
  logic [15:0] inst_pc;

  logic [15:0] rom [256];

  int checks = 0;
  int errors = 0;

  logic [15:0] model_pc = 16'h0;
  int cyc = 0;
  int n_pops = 0;
  int pop_cyc5 = -1;
  int pop_cyc8 = -1;
  int loop_pops = 0;
  int seen_pc10 = 0;

  inst_fetch dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_ready(rom_ready),
    .rom_data(rom_data),
    .rom_valid(rom_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst(inst),
    .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr[7:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Next word decode should see: follow jumps from model_pc until a non-jump word.
  task automatic sb_pop();
    logic [15:0] p;
    logic [15:0] w;
    bit found;
    p = model_pc;
    w = 16'h0;
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      w = rom[p[7:0]];
      if (w[15:12] == 4'hA) p = {8'h00, w[7:0]};
      else found = 1'b1;
    end
    n_pops++;
    if (!found) begin
      check("pop_when_none_expected", 32'd1, 32'd0);
    end else begin
      check("inst", 32'(inst), 32'(w));
      check("inst_pc", 32'(inst_pc), 32'(p));
      model_pc = p + 16'd1;
    end
    if (inst_pc == 16'd5) pop_cyc5 = cyc;
    if (inst_pc == 16'd8) pop_cyc8 = cyc;
    if (inst == 16'h0E00) loop_pops++;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Called mid-cycle: score this cycle's handshake, then cross the edge.
  task automatic cycle_end();
    if (inst_valid && inst_pc == 16'd10) seen_pc10++;
    if (inst_valid && inst_ready) sb_pop();
    @(posedge clk);
    if (rst) model_pc = 16'h0;
    else if (redirect_valid) model_pc = redirect_pc;
    cyc++;
    #1;
  endtask

  initial begin
    int base;
    logic [15:0] w;
    logic [15:0] hold;

    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 | 16'(i);
    rom[0]  = 16'h0008; rom[1]  = 16'h0402; rom[2]  = 16'h2401; rom[3]  = 16'h5100;
    rom[4]  = 16'h9100; rom[5]  = 16'h2001; rom[6]  = 16'hA008; rom[7]  = 16'h5100;
    rom[8]  = 16'h08FF; rom[9]  = 16'h0E00; rom[10] = 16'hA009;

    @(posedge clk);
    #1;

    // Reset held
    repeat (3) begin
      nxt();
      check("rst_rom_ready", 32'(rom_ready), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", 32'(inst), 32'd0);
      cycle_end();
    end

    // Streaming with jump folding and the 9<->10 loop
    rst = 1'b0;
    inst_ready = 1'b1;
    cyc = 0;
    seen_pc10 = 0;
    loop_pops = 0;
    nxt();
    check("first_rom_addr", 32'(rom_addr), 32'h0);
    check("first_rom_ready", 32'(rom_ready), 32'd1);
    cycle_end();
    repeat (39) begin
      nxt();
      cycle_end();
    end
    check("jump_gap_ok", 32'((pop_cyc8 - pop_cyc5) >= 1 && (pop_cyc8 - pop_cyc5) <= 2), 32'd1);
    check("loop_pops", 32'(loop_pops), 32'd16);
    check("never_pc10", 32'(seen_pc10), 32'd0);

    // Backpressure from reset
    rst = 1'b1;
    inst_ready = 1'b0;
    nxt();
    cycle_end();
    rst = 1'b0;
    repeat (6) begin
      nxt();
      cycle_end();
    end
    nxt();
    check("bp_rom_ready", 32'(rom_ready), 32'd0);
    check("bp_pc_hold", 32'(rom_addr), 32'h2);
    check("bp_head", 32'(inst), 32'h0008);
    cycle_end();
    inst_ready = 1'b1;
    base = n_pops;
    repeat (8) begin
      nxt();
      cycle_end();
    end
    check("bp_drain_count", 32'(n_pops - base), 32'd8);

    // rom_valid low: pc holds
    rom_valid = 1'b0;
    nxt();
    hold = rom_addr;
    cycle_end();
    nxt();
    check("no_valid_pc_hold", 32'(rom_addr), 32'(hold));
    cycle_end();
    rom_valid = 1'b1;

    // Redirect with a full queue and decode stalled
    rst = 1'b1;
    inst_ready = 1'b0;
    nxt();
    cycle_end();
    rst = 1'b0;
    repeat (3) begin
      nxt();
      cycle_end();
    end
    redirect_valid = 1'b1;
    redirect_pc = 16'h3;
    nxt();
    check("redir_rom_ready", 32'(rom_ready), 32'd0);
    cycle_end();
    redirect_valid = 1'b0;
    nxt();
    check("redir_inst_valid", 32'(inst_valid), 32'd0);
    check("redir_rom_addr", 32'(rom_addr), 32'h3);
    cycle_end();
    nxt();
    check("redir_head_inst", 32'(inst), 32'h5100);
    check("redir_head_pc", 32'(inst_pc), 32'h3);
    cycle_end();

    // Redirect coinciding with a pop and a valid ROM word
    inst_ready = 1'b1;
    repeat (3) begin
      nxt();
      cycle_end();
    end
    nxt();
    check("t6_head_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0020;
    #1;
    check("t6_rom_ready", 32'(rom_ready), 32'd0);
    base = n_pops;
    cycle_end();
    check("t6_pop_once", 32'(n_pops - base), 32'd1);
    redirect_valid = 1'b0;
    nxt();
    check("t6_inst_valid", 32'(inst_valid), 32'd0);
    check("t6_rom_addr", 32'(rom_addr), 32'h0020);
    cycle_end();
    nxt();
    check("t6_head_inst", 32'(inst), 32'h1020);
    check("t6_head_pc", 32'(inst_pc), 32'h0020);
    cycle_end();

    // Reset while full
    inst_ready = 1'b0;
    repeat (3) begin
      nxt();
      cycle_end();
    end
    nxt();
    check("full_before_rst", 32'(inst_valid), 32'd1);
    cycle_end();
    rst = 1'b1;
    nxt();
    cycle_end();
    nxt();
    check("rst_full_valid", 32'(inst_valid), 32'd0);
    check("rst_full_pc", 32'(rom_addr), 32'h0);
    cycle_end();
    rst = 1'b0;

    // Randomized program and traffic
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        w = {8'hA0, 8'($urandom_range(0, 255))};
      end else begin
        w = 16'($urandom);
        if (w[15:12] == 4'hA) w[15:12] = 4'h3;
      end
      rom[i] = w;
    end
    rst = 1'b1;
    nxt();
    cycle_end();
    rst = 1'b0;
    base = n_pops;
    repeat (3000) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      rom_valid      = ($urandom_range(0, 4) != 0);
      redirect_valid = ($urandom_range(0, 40) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      rst            = ($urandom_range(0, 300) == 0);
      nxt();
      cycle_end();
    end
    check("random_progress", 32'((n_pops - base) > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
